// File: rtl/simd_wave_sequencer.sv
// Multi-wave SIMD issue sequencer: round-robin wave pick, fetch/decode/exec walk, per-cycle lane masks.
// Optional SIMD_PERF_CNT_EN adds saturating instruction/stall counters.

module simd_lane_gate #(
  parameter int LANE = 0
) (
  input  logic        active,
  input  logic [31:0] base,
  input  logic [31:0] threads,
  output logic        lane_on
);
  assign lane_on = active && ((base + 32'(LANE)) < threads);
endmodule

module simd_wave_sequencer #(
  parameter int LANE_WIDTH             = 16,
  parameter int WAVE_SIZE              = 32,
  parameter int NUM_WAVE_SLOTS         = 4,
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  localparam int TOTAL_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
  localparam int SW = (NUM_WAVE_SLOTS > 1) ? $clog2(NUM_WAVE_SLOTS) : 1,
  localparam int CW = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1,
  localparam int TW = $clog2(WAVE_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              dispatch_valid,
  output logic                              dispatch_ready,
  input  logic [31:0]                       dispatch_wave_id,
  input  logic [TW-1:0]                     dispatch_active_threads,
  output logic                              fetch_req,
  input  logic                              fetch_done,
  input  logic                              decode_ret,
  input  logic                              exec_done,
  output logic [2:0]                        simd_state,
  output logic [SW-1:0]                     cur_slot,
  output logic [31:0]                       cur_wave_id,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] cur_pc,
  output logic [CW-1:0]                     cur_wave_cycle,
  output logic [LANE_WIDTH-1:0]             lane_mask,
  output logic                              wave_done,
  output logic [31:0]                       done_wave_id,
  output logic                              busy,
  output logic [31:0]                       perf_instr_count,
  output logic [31:0]                       perf_stall_count
);
  localparam int PAW = PROGRAM_MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, UPDATE = 3'd4, RETIRE = 3'd5
  } state_t;

  typedef struct packed {
    logic           vld;
    logic [PAW-1:0] pc;
    logic [31:0]    id;
    logic [TW-1:0]  thr;
  } slot_t;

  slot_t                     slots [NUM_WAVE_SLOTS];
  state_t                    state_q, state_d;
  logic [SW-1:0]             rr_ptr, cur_slot_q, sel_slot, free_slot;
  logic                      sel_found;
  logic [CW-1:0]             cyc_q;
  logic                      ret_q, fetch_first;
  logic [NUM_WAVE_SLOTS-1:0] vld_vec;
  logic [TW-1:0]             thr_clamp;
  logic                      disp_fire, in_exec, mask_zero, last_cyc, advance;
  logic [31:0]               lane_base, thr_ext;

  for (genvar i = 0; i < NUM_WAVE_SLOTS; i++) begin : g_vld
    assign vld_vec[i] = slots[i].vld;
  end

  // Round-robin: first valid slot strictly after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_slot  = '0;
    for (int k = 1; k <= NUM_WAVE_SLOTS; k++) begin
      if (!sel_found && vld_vec[(int'(rr_ptr) + k) % NUM_WAVE_SLOTS]) begin
        sel_found = 1'b1;
        sel_slot  = SW'((int'(rr_ptr) + k) % NUM_WAVE_SLOTS);
      end
    end
  end

  always_comb begin
    free_slot = '0;
    for (int i = NUM_WAVE_SLOTS - 1; i >= 0; i--) begin
      if (!vld_vec[i]) free_slot = SW'(i);
    end
  end

  assign thr_clamp      = (dispatch_active_threads > TW'(WAVE_SIZE)) ? TW'(WAVE_SIZE)
                                                                     : dispatch_active_threads;
  assign dispatch_ready = enable & ~(&vld_vec);
  // Zero-thread waves complete the handshake but never occupy a slot.
  assign disp_fire      = dispatch_valid & dispatch_ready & (thr_clamp != '0);

  assign in_exec   = (state_q == EXEC);
  assign lane_base = 32'(cyc_q) * 32'(LANE_WIDTH);
  assign thr_ext   = 32'(slots[cur_slot_q].thr);

  for (genvar l = 0; l < LANE_WIDTH; l++) begin : g_lane
    simd_lane_gate #(.LANE(l)) u_lane (
      .active (in_exec),
      .base   (lane_base),
      .threads(thr_ext),
      .lane_on(lane_mask[l])
    );
  end

  assign mask_zero = ~(|lane_mask);
  assign last_cyc  = (cyc_q == CW'(TOTAL_WAVE_CYCLES - 1));
  assign advance   = in_exec & (mask_zero | exec_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    wave_done = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE:    if (sel_found) state_d = FETCH;
        FETCH: begin
          fetch_req = fetch_first;
          if (fetch_done) state_d = DECODE;
        end
        DECODE:  state_d = ret_q ? RETIRE : EXEC;
        EXEC:    if (advance && last_cyc) state_d = UPDATE;
        UPDATE:  state_d = IDLE;
        RETIRE: begin
          wave_done = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAVE_SLOTS; i++) slots[i] <= '0;
      rr_ptr      <= SW'(NUM_WAVE_SLOTS - 1);
      cur_slot_q  <= '0;
      cyc_q       <= '0;
      ret_q       <= 1'b0;
      fetch_first <= 1'b0;
    end else if (enable) begin
      if (disp_fire)
        slots[free_slot] <= '{vld: 1'b1, pc: '0, id: dispatch_wave_id, thr: thr_clamp};
      case (state_q)
        IDLE: if (sel_found) begin
          cur_slot_q  <= sel_slot;
          rr_ptr      <= sel_slot;
          fetch_first <= 1'b1;
        end
        FETCH: begin
          fetch_first <= 1'b0;
          if (fetch_done) ret_q <= decode_ret;
        end
        DECODE: cyc_q <= '0;
        EXEC:   if (advance && !last_cyc) cyc_q <= cyc_q + CW'(1);
        UPDATE: slots[cur_slot_q].pc <= slots[cur_slot_q].pc + PAW'(1);
        RETIRE: slots[cur_slot_q].vld <= 1'b0;
        default: ;
      endcase
    end
  end

  assign simd_state     = state_q;
  assign cur_slot       = cur_slot_q;
  assign cur_wave_id    = slots[cur_slot_q].id;
  assign cur_pc         = slots[cur_slot_q].pc;
  assign cur_wave_cycle = cyc_q;
  assign done_wave_id   = (state_q == RETIRE) ? slots[cur_slot_q].id : '0;
  assign busy           = |vld_vec;

`ifdef SIMD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_count <= '0;
      perf_stall_count <= '0;
    end else if (enable) begin
      if ((state_q == UPDATE || state_q == RETIRE) && perf_instr_count != '1)
        perf_instr_count <= perf_instr_count + 32'd1;
      if (in_exec && !mask_zero && !exec_done && perf_stall_count != '1)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`else
  assign perf_instr_count = '0;
  assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Randomized bench for simd_wave_sequencer against a slot-table reference model.
module tb_simd_wave_sequencer;
  logic        clk = 0, rst = 1, enable = 1;
  logic        dispatch_valid = 0, dispatch_ready;
  logic [31:0] dispatch_wave_id = 0;
  logic [5:0]  dispatch_active_threads = 0;
  logic        fetch_req, fetch_done = 0, decode_ret = 0, exec_done = 0;
  logic [2:0]  simd_state;
  logic [1:0]  cur_slot;
  logic [31:0] cur_wave_id, done_wave_id, perf_instr_count, perf_stall_count;
  logic [5:0]  cur_pc;
  logic [0:0]  cur_wave_cycle;
  logic [15:0] lane_mask;
  logic        wave_done, busy;

  simd_wave_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_wave_id(dispatch_wave_id), .dispatch_active_threads(dispatch_active_threads),
    .fetch_req(fetch_req), .fetch_done(fetch_done), .decode_ret(decode_ret),
    .exec_done(exec_done), .simd_state(simd_state), .cur_slot(cur_slot),
    .cur_wave_id(cur_wave_id), .cur_pc(cur_pc), .cur_wave_cycle(cur_wave_cycle),
    .lane_mask(lane_mask), .wave_done(wave_done), .done_wave_id(done_wave_id),
    .busy(busy), .perf_instr_count(perf_instr_count), .perf_stall_count(perf_stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: a table of resident waves and a round-robin cursor.
  bit          m_valid [4];
  int          m_pc    [4];
  logic [31:0] m_id    [4];
  int          m_thr   [4];
  int          m_rr, m_instr, m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_pc[i] = 0; m_id[i] = 0; m_thr[i] = 0;
    end
    m_rr = 3; m_instr = 0; m_stall = 0;
  endtask

  function automatic bit any_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return 1;
    return 0;
  endfunction

  function automatic bit any_valid();
    for (int i = 0; i < 4; i++) if (m_valid[i]) return 1;
    return 0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= 4; k++) if (m_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] exp_mask(input int thr, input int c);
    int n;
    n = thr - c * 16;
    if (n <= 0) return 16'h0;
    if (n >= 16) return 16'hFFFF;
    return 16'((1 << n) - 1);
  endfunction

  // Drives dispatch for the current cycle (caller steps) and mirrors it in the model.
  task automatic offer(input logic [31:0] id, input int thr);
    dispatch_valid = 1; dispatch_wave_id = id; dispatch_active_threads = 6'(thr);
    #1;
    chk("dispatch_ready", dispatch_ready, any_free());
    if (any_free() && thr != 0) begin
      for (int i = 0; i < 4; i++) if (!m_valid[i]) begin
        m_valid[i] = 1; m_pc[i] = 0; m_id[i] = id; m_thr[i] = (thr > 32) ? 32 : thr;
        break;
      end
    end
  endtask

  task automatic disp_idle(input logic [31:0] id, input int thr);
    offer(id, thr);
    step();
    dispatch_valid = 0;
  endtask

  task automatic chk_perf();
`ifdef SIMD_PERF_CNT_EN
    chk("perf_instr", perf_instr_count, m_instr);
    chk("perf_stall", perf_stall_count, m_stall);
`else
    chk("perf_instr_tied", perf_instr_count, 0);
    chk("perf_stall_tied", perf_stall_count, 0);
`endif
  endtask

  task automatic run_instr(input bit ret, input bit disp, input logic [31:0] did,
                           input int dthr, input bit frz);
    int n, k, d, s;
    logic [15:0] em;
    n = 0;
    while (!fetch_req && n < 12) begin step(); n++; end
    chk("fetch_req_seen", fetch_req, 1);
    if (!fetch_req) return;
    s = pick();
    chk("cur_slot", cur_slot, s);
    chk("cur_wave_id", cur_wave_id, m_id[s]);
    chk("cur_pc", cur_pc, m_pc[s]);
    chk("lane_mask_fetch", lane_mask, 0);
    m_rr = s;
    if (frz) begin
      enable = 0;
      repeat (5) begin
        step();
        chk("frz_state", simd_state, 1);
        chk("frz_pc", cur_pc, m_pc[s]);
        chk("frz_ready", dispatch_ready, 0);
        chk("frz_fetch_req", fetch_req, 0);
        chk_perf();
      end
      enable = 1;
    end
    if (disp) offer(did, dthr);
    d = $urandom_range(0, 2);
    repeat (d) begin
      step(); dispatch_valid = 0;
      chk("fetch_wait", simd_state, 1);
    end
    fetch_done = 1; decode_ret = ret;
    step();
    dispatch_valid = 0; fetch_done = 0; decode_ret = 0;
    chk("decode_state", simd_state, 2);
    step();
    if (ret) begin
      chk("retire_state", simd_state, 5);
      chk("wave_done", wave_done, 1);
      chk("done_wave_id", done_wave_id, m_id[s]);
      m_valid[s] = 0; m_instr++;
      step();
      chk("wave_done_pulse", wave_done, 0);
    end else begin
      for (int c = 0; c < 2; c++) begin
        em = exp_mask(m_thr[s], c);
        chk("exec_state", simd_state, 3);
        chk("wave_cycle", cur_wave_cycle, c);
        chk("lane_mask", lane_mask, em);
        if (em != 0) begin
          k = $urandom_range(0, 2);
          repeat (k) begin step(); chk("stall_mask", lane_mask, em); end
          m_stall += k;
          exec_done = 1; step(); exec_done = 0;
        end else step();
      end
      chk("update_state", simd_state, 4);
      step();
      m_pc[s] = (m_pc[s] + 1) % 64; m_instr++;
    end
    chk("back_idle", simd_state, 0);
    chk("busy", busy, any_valid());
    chk_perf();
  endtask

  task automatic do_reset();
    rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    model_reset();
  endtask

  initial begin
    int thr_tab [6];
    int t;
    thr_tab = '{0, 5, 20, 32, 40, 1};
    model_reset();
    do_reset();
    chk("rst_state", simd_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_mask", lane_mask, 0);
    chk("rst_pc", cur_pc, 0);
    chk("rst_ready", dispatch_ready, 1);
    chk("rst_wave_done", wave_done, 0);
    chk_perf();

    // Basic flow, partial masks and a zero-mask wave cycle.
    disp_idle(32'd7, 32);
    run_instr(0, 1, 32'd99, 20, 0);
    run_instr(0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0);
    run_instr(0, 1, 32'd55, 5, 0);
    run_instr(0, 0, 0, 0, 0);
    while (any_valid()) run_instr(1, 0, 0, 0, 0);

    // Three-wave round robin, RET on wave 11, immediate refill of its slot.
    disp_idle(32'd10, 32);
    run_instr(0, 1, 32'd11, 32, 0);
    run_instr(0, 1, 32'd12, 20, 0);
    run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0);
    run_instr(0, 1, 32'd13, 5, 0);
    run_instr(0, 1, 32'd14, 40, 0);
    run_instr(0, 1, 32'd15, 32, 0);
    chk("full_ready", dispatch_ready, 0);
    run_instr(0, 1, 32'd16, 32, 0);
    while (any_valid()) run_instr(1, 0, 0, 0, 0);

    // Zero-thread drop and thread clamp.
    disp_idle(32'd20, 0);
    chk("drop_busy", busy, 0);
    step();
    chk("drop_idle", simd_state, 0);
    disp_idle(32'd21, 40);
    for (int i = 0; i < 65; i++) run_instr(0, 0, 0, 0, (i == 3));
    run_instr(1, 0, 0, 0, 0);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      if (!any_valid()) begin
        t = thr_tab[$urandom_range(0, 5)];
        if (t == 1) t = $urandom_range(1, 32);
        if (t == 0) t = 9;
        disp_idle($urandom, t);
      end
      t = thr_tab[$urandom_range(0, 5)];
      if (t == 1) t = $urandom_range(1, 32);
      run_instr(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom, t,
                ($urandom_range(0, 40) == 0));
    end

    // Reset in the middle of EXEC.
    while (any_valid()) run_instr(1, 0, 0, 0, 0);
    disp_idle(32'd77, 32);
    t = 0;
    while (!fetch_req && t < 12) begin step(); t++; end
    fetch_done = 1; step(); fetch_done = 0;
    step();
    chk("pre_rst_exec", simd_state, 3);
    rst = 1;
    #1;
    chk("mid_rst_state", simd_state, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mask", lane_mask, 0);
    chk("mid_rst_id", cur_wave_id, 0);
    chk("mid_rst_pc", cur_pc, 0);
    @(negedge clk); rst = 0;
    model_reset();
    chk_perf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/simd_wave_sequencer.md
Name: simd_wave_sequencer

Overview:
Multi-wave issue sequencer for one SIMD unit. Holds up to NUM_WAVE_SLOTS resident wavefronts, each with its own PC and active-thread count. Picks one wave per instruction round-robin and walks it through fetch, decode and execute. Splits each instruction into ceil(WAVE_SIZE/LANE_WIDTH) wave cycles with a per-cycle lane mask. Sits between the wave dispatcher and the fetcher/decoder/lane datapath; replaces the single-wave PC/controller path.

Parameters:
- LANE_WIDTH, 16, lanes per wave cycle
- WAVE_SIZE, 32, threads per wavefront
- NUM_WAVE_SLOTS, 4, resident wave slots (>=1)
- PROGRAM_MEM_ADDR_WIDTH, 6, PC width
- Derived: TOTAL_WAVE_CYCLES=ceil(WAVE_SIZE/LANE_WIDTH); SW=max(1,clog2(NUM_WAVE_SLOTS)); CW=max(1,clog2(TOTAL_WAVE_CYCLES)); TW=clog2(WAVE_SIZE+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  freeze when low
- dispatch_valid  in  1  new wave offered
- dispatch_ready  out  1  free slot available
- dispatch_wave_id  in  32  wave id
- dispatch_active_threads  in  TW  valid threads in wave
- fetch_req  out  1  one-cycle fetch request for cur_pc
- fetch_done  in  1  instruction fetched
- decode_ret  in  1  fetched instruction is RET, sampled with fetch_done
- exec_done  in  1  lanes finished current wave cycle
- simd_state  out  3  FSM state
- cur_slot  out  SW  selected slot
- cur_wave_id  out  32  wave id of selected slot
- cur_pc  out  PROGRAM_MEM_ADDR_WIDTH  PC of selected slot
- cur_wave_cycle  out  CW  current wave cycle
- lane_mask  out  LANE_WIDTH  active lanes this cycle
- wave_done  out  1  one-cycle retire pulse
- done_wave_id  out  32  id of retired wave
- busy  out  1  any slot valid

Behaviour:
- Reset (async, any time, abandons in-flight work):
  - all slot valid bits, pcs and outputs 0
  - state IDLE
  - round-robin pointer = NUM_WAVE_SLOTS-1, so slot 0 is picked first
- enable low: all registers hold; fetch_req and wave_done forced 0; dispatch_ready 0.
- Dispatch:
  - dispatch_ready = enable & any slot invalid
  - On valid&ready, the lowest-index free slot is loaded: valid=1, pc=0, id, threads
  - threads>WAVE_SIZE is clamped to WAVE_SIZE
  - threads==0 is accepted and dropped: no slot allocated, no wave_done
- States (encoding IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, RETIRE=5):
  - IDLE: if any slot valid, select the first valid slot after the rr pointer (wrapping), update the pointer, go to FETCH. A slot written this same edge is not eligible.
  - FETCH: fetch_req is high only in the first FETCH cycle. Wait for fetch_done, latch decode_ret, go to DECODE. fetch_done in the request cycle is legal.
  - DECODE: one cycle. If the latched ret is set go to RETIRE, else EXEC with cur_wave_cycle=0.
  - EXEC: lane_mask[l]=1 iff cur_wave_cycle*LANE_WIDTH+l < threads.
    - Mask nonzero: wait for exec_done.
    - Mask zero: advance immediately; exec_done is ignored.
    - On advance: if cur_wave_cycle==TOTAL_WAVE_CYCLES-1 go to UPDATE, else increment cur_wave_cycle.
  - UPDATE: slot pc <= pc+1, wrapping modulo 2^PROGRAM_MEM_ADDR_WIDTH; go to IDLE.
  - RETIRE: clear slot valid; wave_done=1 with done_wave_id for exactly that cycle; go to IDLE.
- lane_mask is 0 outside EXEC.
- A slot freed in RETIRE can accept a dispatch from the next cycle.
- Dispatch into other slots during any state never disturbs the selected slot.

Optional Feature:
- SIMD_PERF_CNT_EN defined:
  - adds outputs perf_instr_count[31:0] and perf_stall_count[31:0]
  - perf_instr_count increments per UPDATE or RETIRE
  - perf_stall_count increments per EXEC cycle with nonzero mask and exec_done low
  - both saturate at 0xFFFFFFFF, reset to 0, hold while enable is low
- Not defined: both ports still present, tied to 0, no counter logic.

Test Plan:
- Defaults; dispatch id=7, threads=32; fetch_done 1 cycle after request, ret=0, exec_done each cycle -> masks 0xFFFF then 0xFFFF, pc 0->1, back to IDLE.
- Dispatch threads=20 -> EXEC masks 0xFFFF then 0x000F. Threads=5 -> 0x001F, then cycle 1 skipped with no exec_done wait.
- Dispatch ids 10, 11, 12 into slots 0-2 -> issue order slots 0,1,2,0,...; each pc advances once per turn.
- Wave id 11 hits RET -> wave_done 1 cycle with done_wave_id=11; slot 1 freed; a dispatch the next cycle lands in slot 1 with pc=0.
- Fill all 4 slots -> dispatch_ready=0. Threads=40 is clamped to 32. Threads=0 produces no allocation. PC 63 increments to 0.
- Assert rst mid-EXEC -> all outputs 0 immediately, busy=0. Deassert enable for 5 cycles mid-FETCH -> state and pc unchanged; with SIMD_PERF_CNT_EN, counters unchanged during the freeze.
